// File: rtl/sqrt_fp_pkg.sv
// Shared definitions for the square-root / inverse-square-root job arbiter.
// Contents:
//   state_e              - FSM states of sqrt_fp_arbiter
//   OP_SQRT / OP_INVSQRT - per-requester operation encodings
//   FLAG_*_IDX           - bit positions inside rsp_flags_o {overflow, underflow, toRound}
//   DEFAULT_TIMEOUT_CYC  - default WAIT budget before a job is aborted
//   onehot2_to_id        - converts a 2-way one-hot grant to a requester index
package sqrt_fp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic OP_SQRT    = 1'b0;
    localparam logic OP_INVSQRT = 1'b1;

    localparam int unsigned FLAG_OVF_IDX = 32'd2;
    localparam int unsigned FLAG_UNF_IDX = 32'd1;
    localparam int unsigned FLAG_RND_IDX = 32'd0;

    localparam int unsigned DEFAULT_TIMEOUT_CYC = 32'd64;

    // Index of the granted requester; only meaningful for a one-hot input.
    function automatic logic onehot2_to_id(input logic [1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   req     [1:0] - request vector, bit r = requester r
//   pointer       - index of the requester granted last; loses a tie
//   grant   [1:0] - one-hot grant, or zero when nobody requests
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant
);

    // Grant the sole requester, or on a tie the one not granted last.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/sqrt_fp_arbiter.sv
// Arbitrates two requesters onto one shared SQRT / INVSQRT unit.
// A granted job's operands are latched, a one-cycle start strobe is issued,
// the unit's result (or a timeout) is captured and returned to the owner
// of the job, which must handshake it before the next job is accepted.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   req_*               - per-requester job request (valid/ready, op, s, f, e)
//   rsp_valid_o/ready_i - per-requester response handshake
//   rsp_s/f/e/flags/timeout_o - shared result bus
//   doSqrt_o, doInvSqrt_o, u_rst_o, u_s/f/e_o - unit control and operands
//   u_valid_i, u_s/f/e_i, u_is*_i             - unit result and status flags
module sqrt_fp_arbiter
    import sqrt_fp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [1:0]        req_s_i,
    input  logic [15:0]       req_f_i,
    input  logic [15:0]       req_e_i,
    output logic [1:0]        rsp_valid_o,
    input  logic [1:0]        rsp_ready_i,
    output logic              rsp_s_o,
    output logic [11:0]       rsp_f_o,
    output logic signed [7:0] rsp_e_o,
    output logic [2:0]        rsp_flags_o,
    output logic              rsp_timeout_o,
    output logic              doSqrt_o,
    output logic              doInvSqrt_o,
    output logic              u_rst_o,
    output logic              u_s_o,
    output logic [7:0]        u_f_o,
    output logic [7:0]        u_e_o,
    input  logic              u_valid_i,
    input  logic              u_s_i,
    input  logic [11:0]       u_f_i,
    input  logic [7:0]        u_e_i,
    input  logic              u_isOverflow_i,
    input  logic              u_isUnderflow_i,
    input  logic              u_isToRound_i
);

    // One spare bit so the counter never wraps before the timeout compare.
    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYC) + 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    state_e            state_r;
    state_e            state_nxt_s;
    logic              ptr_r;
    logic              id_r;
    logic              op_r;
    logic              opd_s_r;
    logic [7:0]        opd_f_r;
    logic [7:0]        opd_e_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              res_s_r;
    logic [11:0]       res_f_r;
    logic [7:0]        res_e_r;
    logic [2:0]        res_flags_r;
    logic              res_to_r;

    logic [1:0]        gnt_s;
    logic              gnt_id_s;
    logic              any_gnt_s;
    logic              valid_ok_s;
    logic              timeout_s;
    logic              resp_done_s;

    rr_arbiter2 u_rr (
        .req     (req_valid_i),
        .pointer (ptr_r),
        .grant   (gnt_s)
    );

    // Job-level events derived from the current state.
    always_comb begin
        gnt_id_s    = onehot2_to_id(gnt_s);
        any_gnt_s   = (state_r == ST_IDLE) && (gnt_s != 2'b00);
        // The first WAIT cycle ignores u_valid_i so a valid left over from
        // the previous job cannot be mistaken for this job's result.
        valid_ok_s  = (state_r == ST_WAIT) && u_valid_i && (cnt_r != CNT_ZERO);
        // A qualifying valid in the last cycle beats the timeout.
        timeout_s   = (state_r == ST_WAIT) && !valid_ok_s && (cnt_r == CNT_LAST);
        resp_done_s = (state_r == ST_RESP) && rsp_ready_i[id_r];
    end

    // Next-state logic of the job FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_gnt_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (valid_ok_s || timeout_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, arbitration pointer, operand, counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 1'b1;
            id_r        <= 1'b0;
            op_r        <= OP_SQRT;
            opd_s_r     <= 1'b0;
            opd_f_r     <= 8'h00;
            opd_e_r     <= 8'h00;
            cnt_r       <= CNT_ZERO;
            res_s_r     <= 1'b0;
            res_f_r     <= 12'h000;
            res_e_r     <= 8'h00;
            res_flags_r <= 3'b000;
            res_to_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (any_gnt_s) begin
                        ptr_r   <= gnt_id_s;
                        id_r    <= gnt_id_s;
                        op_r    <= req_op_i[gnt_id_s];
                        opd_s_r <= req_s_i[gnt_id_s];
                        opd_f_r <= req_f_i[{gnt_id_s, 3'b000} +: 8];
                        opd_e_r <= req_e_i[{gnt_id_s, 3'b000} +: 8];
                    end
                end
                ST_ISSUE: begin
                    cnt_r <= CNT_ZERO;
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (valid_ok_s) begin
                        res_s_r                   <= u_s_i;
                        res_f_r                   <= u_f_i;
                        res_e_r                   <= u_e_i;
                        res_flags_r[FLAG_OVF_IDX] <= u_isOverflow_i;
                        res_flags_r[FLAG_UNF_IDX] <= u_isUnderflow_i;
                        res_flags_r[FLAG_RND_IDX] <= u_isToRound_i;
                        res_to_r                  <= 1'b0;
                    end else if (timeout_s) begin
                        res_s_r     <= 1'b0;
                        res_f_r     <= 12'h000;
                        res_e_r     <= 8'h00;
                        res_flags_r <= 3'b000;
                        res_to_r    <= 1'b1;
                    end
                end
                ST_RESP: begin
                    res_to_r <= res_to_r;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode; everything is forced low during reset except u_rst_o,
    // which holds the unit in reset alongside this block.
    always_comb begin
        req_ready_o   = 2'b00;
        rsp_valid_o   = 2'b00;
        rsp_s_o       = 1'b0;
        rsp_f_o       = 12'h000;
        rsp_e_o       = 8'sh00;
        rsp_flags_o   = 3'b000;
        rsp_timeout_o = 1'b0;
        doSqrt_o      = 1'b0;
        doInvSqrt_o   = 1'b0;
        u_rst_o       = 1'b1;
        u_s_o         = 1'b0;
        u_f_o         = 8'h00;
        u_e_o         = 8'h00;
        if (rst) begin
            if (state_r == ST_IDLE) begin
                req_ready_o = gnt_s;
            end else begin
                req_ready_o = 2'b00;
            end
            if (state_r == ST_RESP) begin
                rsp_valid_o = id_r ? 2'b10 : 2'b01;
            end else begin
                rsp_valid_o = 2'b00;
            end
            rsp_s_o       = res_s_r;
            rsp_f_o       = res_f_r;
            rsp_e_o       = res_e_r;
            rsp_flags_o   = res_flags_r;
            rsp_timeout_o = res_to_r;
            doSqrt_o      = (state_r == ST_ISSUE) && (op_r == OP_SQRT);
            doInvSqrt_o   = (state_r == ST_ISSUE) && (op_r == OP_INVSQRT);
            // Pulses only in the cycle that aborts a hung unit.
            u_rst_o       = timeout_s;
            u_s_o         = opd_s_r;
            u_f_o         = opd_f_r;
            u_e_o         = opd_e_r;
        end else begin
            u_rst_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_sqrt_fp_arbiter.sv
module tb_sqrt_fp_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid_i = 2'b00;
    logic [1:0]  req_ready_o;
    logic [1:0]  req_op_i = 2'b00;
    logic [1:0]  req_s_i = 2'b00;
    logic [15:0] req_f_i = 16'h0000;
    logic [15:0] req_e_i = 16'h0000;
    logic [1:0]  rsp_valid_o;
    logic [1:0]  rsp_ready_i = 2'b00;
    logic        rsp_s_o;
    logic [11:0] rsp_f_o;
    logic [7:0]  rsp_e_o;
    logic [2:0]  rsp_flags_o;
    logic        rsp_timeout_o;
    logic        doSqrt_o;
    logic        doInvSqrt_o;
    logic        u_rst_o;
    logic        u_s_o;
    logic [7:0]  u_f_o;
    logic [7:0]  u_e_o;
    logic        u_valid_i = 1'b0;
    logic        u_s_i = 1'b0;
    logic [11:0] u_f_i = 12'h000;
    logic [7:0]  u_e_i = 8'h00;
    logic        u_isOverflow_i = 1'b0;
    logic        u_isUnderflow_i = 1'b0;
    logic        u_isToRound_i = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    sqrt_fp_arbiter #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_s_i(req_s_i), .req_f_i(req_f_i), .req_e_i(req_e_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_s_o(rsp_s_o), .rsp_f_o(rsp_f_o), .rsp_e_o(rsp_e_o),
        .rsp_flags_o(rsp_flags_o), .rsp_timeout_o(rsp_timeout_o),
        .doSqrt_o(doSqrt_o), .doInvSqrt_o(doInvSqrt_o), .u_rst_o(u_rst_o),
        .u_s_o(u_s_o), .u_f_o(u_f_o), .u_e_o(u_e_o),
        .u_valid_i(u_valid_i), .u_s_i(u_s_i), .u_f_i(u_f_i), .u_e_i(u_e_i),
        .u_isOverflow_i(u_isOverflow_i), .u_isUnderflow_i(u_isUnderflow_i),
        .u_isToRound_i(u_isToRound_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        req_valid_i = 2'b11;
        tick(); tick();
        total_cnt++;
        if (req_ready_o !== 2'b00 || rsp_valid_o !== 2'b00)
            $display("FAIL reset_handshake: ready=%b rsp_valid=%b want 00/00", req_ready_o, rsp_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (u_rst_o !== 1'b1 || doSqrt_o !== 1'b0 || doInvSqrt_o !== 1'b0)
            $display("FAIL reset_unit: u_rst=%b sqrt=%b inv=%b want 1/0/0", u_rst_o, doSqrt_o, doInvSqrt_o);
        else pass_cnt++;
        total_cnt++;
        if (rsp_f_o !== 12'h000 || rsp_timeout_o !== 1'b0 || u_f_o !== 8'h00)
            $display("FAIL reset_data: rsp_f=%h to=%b u_f=%h want 0", rsp_f_o, rsp_timeout_o, u_f_o);
        else pass_cnt++;
        req_valid_i = 2'b00;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (u_rst_o !== 1'b0 || req_ready_o !== 2'b00)
            $display("FAIL reset_release: u_rst=%b ready=%b want 0/00", u_rst_o, req_ready_o);
        else pass_cnt++;
    endtask

    task automatic test_single_job();
        int pulses;
        pulses = 0;
        req_valid_i = 2'b01; req_op_i = 2'b00; req_s_i = 2'b00;
        req_f_i = 16'h0040; req_e_i = 16'h0004;
        #1;
        total_cnt++;
        if (req_ready_o !== 2'b01) $display("FAIL single_grant: got %b want 01", req_ready_o);
        else pass_cnt++;
        tick();
        req_valid_i = 2'b00;
        if (doSqrt_o === 1'b1) pulses++;
        total_cnt++;
        if (doInvSqrt_o !== 1'b0 || u_f_o !== 8'h40 || u_e_o !== 8'h04 || u_s_o !== 1'b0)
            $display("FAIL single_issue: inv=%b u_f=%h u_e=%h u_s=%b want 0/40/04/0", doInvSqrt_o, u_f_o, u_e_o, u_s_o);
        else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (doSqrt_o === 1'b1) pulses++;
            total_cnt++;
            if (rsp_valid_o !== 2'b00 || u_f_o !== 8'h40)
                $display("FAIL single_wait%0d: rsp_valid=%b u_f=%h want 00/40", i, rsp_valid_o, u_f_o);
            else pass_cnt++;
        end
        tick();
        if (doSqrt_o === 1'b1) pulses++;
        u_valid_i = 1'b1; u_s_i = 1'b1; u_f_i = 12'hABC; u_e_i = 8'hF3;
        u_isOverflow_i = 1'b1; u_isUnderflow_i = 1'b0; u_isToRound_i = 1'b1;
        tick();
        u_valid_i = 1'b0; u_s_i = 1'b0; u_f_i = 12'h000; u_e_i = 8'h00;
        u_isOverflow_i = 1'b0; u_isToRound_i = 1'b0;
        req_valid_i = 2'b01;
        #1;
        total_cnt++;
        if (rsp_valid_o !== 2'b01 || rsp_f_o !== 12'hABC || rsp_e_o !== 8'hF3 || rsp_s_o !== 1'b1)
            $display("FAIL single_rsp: valid=%b f=%h e=%h s=%b want 01/abc/f3/1", rsp_valid_o, rsp_f_o, rsp_e_o, rsp_s_o);
        else pass_cnt++;
        total_cnt++;
        if (rsp_flags_o !== 3'b101 || rsp_timeout_o !== 1'b0)
            $display("FAIL single_flags: flags=%b to=%b want 101/0", rsp_flags_o, rsp_timeout_o);
        else pass_cnt++;
        total_cnt++;
        if (req_ready_o !== 2'b00) $display("FAIL single_no_grant_in_resp: got %b want 00", req_ready_o);
        else pass_cnt++;
        total_cnt++;
        if (pulses !== 1) $display("FAIL single_sqrt_pulses: got %0d want 1", pulses);
        else pass_cnt++;
        tick();
        req_valid_i = 2'b00;
        total_cnt++;
        if (rsp_valid_o !== 2'b01 || rsp_f_o !== 12'hABC)
            $display("FAIL single_hold: valid=%b f=%h want 01/abc", rsp_valid_o, rsp_f_o);
        else pass_cnt++;
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
        total_cnt++;
        if (rsp_valid_o !== 2'b00) $display("FAIL single_done: rsp_valid=%b want 00", rsp_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_tie();
        logic [1:0]  exp_g;
        logic [7:0]  exp_uf;
        logic [11:0] exp_rf;
        rst = 1'b0; tick(); rst = 1'b1;
        req_op_i = 2'b10; req_f_i = 16'h2211; req_e_i = 16'h0201;
        for (int j = 0; j < 4; j++) begin
            exp_g  = (j % 2 == 0) ? 2'b01 : 2'b10;
            exp_uf = (j % 2 == 0) ? 8'h11 : 8'h22;
            exp_rf = 12'h100 + 12'(j);
            req_valid_i = 2'b11;
            #1;
            total_cnt++;
            if (req_ready_o !== exp_g) $display("FAIL tie_grant%0d: got %b want %b", j, req_ready_o, exp_g);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (doSqrt_o !== exp_g[0] || doInvSqrt_o !== exp_g[1] || u_f_o !== exp_uf || req_ready_o !== 2'b00)
                $display("FAIL tie_issue%0d: sqrt=%b inv=%b u_f=%h ready=%b want %b/%b/%h/00",
                         j, doSqrt_o, doInvSqrt_o, u_f_o, req_ready_o, exp_g[0], exp_g[1], exp_uf);
            else pass_cnt++;
            tick(); tick();
            u_valid_i = 1'b1; u_f_i = exp_rf;
            tick();
            u_valid_i = 1'b0;
            total_cnt++;
            if (rsp_valid_o !== exp_g || rsp_f_o !== exp_rf)
                $display("FAIL tie_rsp%0d: valid=%b f=%h want %b/%h", j, rsp_valid_o, rsp_f_o, exp_g, exp_rf);
            else pass_cnt++;
            rsp_ready_i = exp_g;
            tick();
            rsp_ready_i = 2'b00;
        end
        req_valid_i = 2'b00;
    endtask

    task automatic test_stale_valid();
        req_valid_i = 2'b01; req_op_i = 2'b00; req_f_i = 16'h0055;
        tick();
        req_valid_i = 2'b00;
        u_valid_i = 1'b1; u_f_i = 12'h111;
        tick();
        tick();
        u_valid_i = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            total_cnt++;
            if (rsp_valid_o !== 2'b00) $display("FAIL stale_early%0d: rsp_valid=%b want 00", i, rsp_valid_o);
            else pass_cnt++;
            if (i < 5) tick();
        end
        u_valid_i = 1'b1; u_f_i = 12'h222;
        tick();
        u_valid_i = 1'b0;
        total_cnt++;
        if (rsp_valid_o !== 2'b01 || rsp_f_o !== 12'h222)
            $display("FAIL stale_rsp: valid=%b f=%h want 01/222", rsp_valid_o, rsp_f_o);
        else pass_cnt++;
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
    endtask

    task automatic test_timeout();
        req_valid_i = 2'b10; req_op_i = 2'b10; req_f_i = 16'h7700; req_e_i = 16'h0500;
        #1;
        total_cnt++;
        if (req_ready_o !== 2'b10) $display("FAIL to_grant: got %b want 10", req_ready_o);
        else pass_cnt++;
        tick();
        req_valid_i = 2'b00;
        total_cnt++;
        if (doInvSqrt_o !== 1'b1 || doSqrt_o !== 1'b0)
            $display("FAIL to_issue: inv=%b sqrt=%b want 1/0", doInvSqrt_o, doSqrt_o);
        else pass_cnt++;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total_cnt++;
            if (u_rst_o !== (i == 8) || rsp_valid_o !== 2'b00)
                $display("FAIL to_wait%0d: u_rst=%b rsp_valid=%b want %b/00", i, u_rst_o, rsp_valid_o, (i == 8));
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (rsp_valid_o !== 2'b10 || rsp_timeout_o !== 1'b1 || u_rst_o !== 1'b0)
            $display("FAIL to_rsp: valid=%b to=%b u_rst=%b want 10/1/0", rsp_valid_o, rsp_timeout_o, u_rst_o);
        else pass_cnt++;
        total_cnt++;
        if (rsp_f_o !== 12'h000 || rsp_e_o !== 8'h00 || rsp_s_o !== 1'b0 || rsp_flags_o !== 3'b000)
            $display("FAIL to_zero: f=%h e=%h s=%b flags=%b want 0", rsp_f_o, rsp_e_o, rsp_s_o, rsp_flags_o);
        else pass_cnt++;
        rsp_ready_i = 2'b10;
        tick();
        rsp_ready_i = 2'b00;
        // Unit answers in the very cycle the timeout would fire.
        req_valid_i = 2'b01; req_op_i = 2'b00;
        tick();
        req_valid_i = 2'b00;
        for (int i = 1; i <= 8; i++) tick();
        u_valid_i = 1'b1; u_f_i = 12'h3C5; u_e_i = 8'h80; u_isUnderflow_i = 1'b1;
        #1;
        total_cnt++;
        if (u_rst_o !== 1'b0) $display("FAIL to_race_urst: got %b want 0", u_rst_o);
        else pass_cnt++;
        tick();
        u_valid_i = 1'b0; u_isUnderflow_i = 1'b0;
        total_cnt++;
        if (rsp_valid_o !== 2'b01 || rsp_timeout_o !== 1'b0 || rsp_f_o !== 12'h3C5 || rsp_flags_o !== 3'b010)
            $display("FAIL to_race_rsp: valid=%b to=%b f=%h flags=%b want 01/0/3c5/010",
                     rsp_valid_o, rsp_timeout_o, rsp_f_o, rsp_flags_o);
        else pass_cnt++;
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
    endtask

    task automatic test_backpressure();
        req_valid_i = 2'b01; req_op_i = 2'b00; req_f_i = 16'h00A5;
        tick();
        req_valid_i = 2'b00;
        tick(); tick();
        u_valid_i = 1'b1; u_f_i = 12'h5A5;
        tick();
        u_valid_i = 1'b0;
        req_valid_i = 2'b11;
        for (int i = 0; i < 10; i++) begin
            rsp_ready_i = (i % 2 == 1) ? 2'b10 : 2'b00;
            #1;
            total_cnt++;
            if (rsp_valid_o !== 2'b01 || rsp_f_o !== 12'h5A5 || req_ready_o !== 2'b00)
                $display("FAIL bp_hold%0d: valid=%b f=%h ready=%b want 01/5a5/00", i, rsp_valid_o, rsp_f_o, req_ready_o);
            else pass_cnt++;
            tick();
        end
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
        #1;
        total_cnt++;
        if (req_ready_o !== 2'b10 || rsp_valid_o !== 2'b00)
            $display("FAIL bp_next_grant: ready=%b valid=%b want 10/00", req_ready_o, rsp_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        req_op_i = 2'b10;
        tick();
        tick(); tick();
        rst = 1'b0; u_valid_i = 1'b1; req_valid_i = 2'b11;
        #1;
        total_cnt++;
        if (rsp_valid_o !== 2'b00 || u_rst_o !== 1'b1 || req_ready_o !== 2'b00 || rsp_f_o !== 12'h000 || u_f_o !== 8'h00)
            $display("FAIL mid_reset_out: valid=%b u_rst=%b ready=%b f=%h u_f=%h want 00/1/00/0/0",
                     rsp_valid_o, u_rst_o, req_ready_o, rsp_f_o, u_f_o);
        else pass_cnt++;
        tick();
        u_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (req_ready_o !== 2'b01 || rsp_valid_o !== 2'b00)
            $display("FAIL mid_reset_tie: ready=%b valid=%b want 01/00", req_ready_o, rsp_valid_o);
        else pass_cnt++;
        tick();
        req_valid_i = 2'b00;
        total_cnt++;
        if (doSqrt_o !== 1'b1 || rsp_f_o !== 12'h000)
            $display("FAIL mid_reset_issue: sqrt=%b f=%h want 1/000", doSqrt_o, rsp_f_o);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (rsp_valid_o !== 2'b00) $display("FAIL mid_reset_norsp%0d: valid=%b want 00", i, rsp_valid_o);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_tie();
        test_stale_valid();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/sqrt_fp_arbiter.md
SQRT_FP_ARBITER -- requirements
Module: sqrt_fp_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: maximum WAIT cycles before the job is aborted.
REQ-002 clk  in  1  single clock; every flop updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-low (0 = reset).
REQ-004 req_valid_i  in  2  requester r presents a job.
REQ-005 req_ready_o  out  2  job accepted this cycle; one-hot or zero.
REQ-006 req_op_i  in  2  per-requester op: 0 = SQRT, 1 = INVSQRT.
REQ-007 req_s_i  in  2; req_f_i  in  16; req_e_i  in  16: per-requester sign, 8-bit mantissa and signed 8-bit exponent; requester r uses bits [8r+7:8r].
REQ-008 rsp_valid_o  out  2  result ready for requester r; one-hot or zero.
REQ-009 rsp_ready_i  in  2  requester r takes the result.
REQ-010 rsp_s_o 1, rsp_f_o 12, rsp_e_o 8 signed, rsp_flags_o 3 {overflow, underflow, toRound}, rsp_timeout_o 1: all outputs, shared result bus.
REQ-011 Unit side: doSqrt_o, doInvSqrt_o, u_rst_o, u_s_o (1), u_f_o (8), u_e_o (8) are outputs; u_valid_i, u_s_i (1), u_f_i (12), u_e_i (8), u_isOverflow_i, u_isUnderflow_i, u_isToRound_i are inputs.

Function
REQ-012 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-013 IDLE: if any req_valid_i is set, the 2-way round-robin winner gets req_ready_o=1 combinationally. Op, s, f, e and the requester id are latched, and the FSM moves to ISSUE.
REQ-014 Round-robin rule: if both requesters are valid, the requester not granted last wins. The pointer updates at each grant.
REQ-015 ISSUE lasts exactly 1 cycle. doSqrt_o=1 if op=0, otherwise doInvSqrt_o=1; the other strobe stays 0. The wait counter clears, and the FSM moves to WAIT.
REQ-016 u_s_o, u_f_o and u_e_o carry the latched operands and stay stable from ISSUE through the end of WAIT.
REQ-017 WAIT: the counter increments each cycle. u_valid_i is ignored in ISSUE and in the first WAIT cycle (counter=0); this masks a stale valid from the previous job.
REQ-018 WAIT, u_valid_i=1 with counter>=1: latch u_s_i, u_f_i, u_e_i and the three flags, set rsp_timeout_o=0, and move to RESP.
REQ-019 WAIT, counter=TIMEOUT_CYC-1 with no valid: move to RESP with rsp_timeout_o=1 and zeroed s, f, e and flags. u_rst_o=1 for that single transition cycle.
REQ-020 If u_valid_i and the timeout condition occur in the same cycle, valid wins and there is no timeout.
REQ-021 RESP: rsp_valid_o[id]=1 with the result held stable until rsp_ready_i[id]=1, then move to IDLE. rsp_ready_i of the other requester is ignored.
REQ-022 A new job is never accepted before the current response handshakes; req_ready_o=0 outside IDLE.
REQ-023 Latency with an immediately ready unit: accept at cycle 0, ISSUE at cycle 1, earliest rsp_valid_o one cycle after the first qualifying u_valid_i sample.
REQ-024 Deasserting req_valid_i before a grant has no effect.
REQ-025 Operands are passed through unmodified; no arithmetic is performed on them.

Reset
REQ-026 While rst=0, on the next edge: state=IDLE, round-robin pointer=1 (so requester 0 wins the first tie), counter=0, and all result registers are 0.
REQ-027 While rst=0, all outputs are 0, except u_rst_o=1 so the unit resets together with this block.
REQ-028 Reset mid-operation aborts the job with no response. Normal arbitration resumes in the first cycle after rst returns to 1.

Structure
REQ-029 The shared package sqrt_fp_pkg holds:
- the FSM state enumeration;
- the op encodings (SQRT=0, INVSQRT=1);
- the flag bit indices;
- the default TIMEOUT_CYC.
REQ-030 The round-robin grant logic lives in one sub-module, rr_arbiter2 (inputs: req, pointer; output: one-hot grant). The FSM, counter and result registers stay in sqrt_fp_arbiter.

Verification
REQ-031 Single job: req0 SQRT, f=0x40, e=4; unit valid 5 cycles after ISSUE -> doSqrt_o pulses exactly once, and rsp_valid_o=01 carries the unit's f, e and flags with rsp_timeout_o=0.
REQ-032 Tie: both requesters valid from reset, req1 INVSQRT -> grant order 0,1,0,1, and doInvSqrt_o pulses only for req1's jobs.
REQ-033 Stale valid: u_valid_i held 1 during ISSUE and the first WAIT cycle, then 0, then 1 three cycles later -> the result is latched only at the later pulse.
REQ-034 Timeout: TIMEOUT_CYC=8, unit never valid -> rsp_timeout_o=1 with zeroed result, u_rst_o is a one-cycle pulse, and the next job proceeds normally.
REQ-035 Backpressure and reset: rsp_ready_i withheld for 10 cycles -> result stable and no new grant. rst=0 during WAIT -> no response, IDLE afterwards, and req0 wins the next tie.
